// File: rtl/mux_rr_nx1.sv
// N-to-1 multiplexer with a registered output and valid/ready handshakes.
// The grant comes from one of two sources:
// - Fixed mode: the external select.
// - Round-robin mode: a scan over the valid channels, starting at rr_ptr.
// The output register adds one cycle of latency. It can drain and reload on the
// same edge, so full throughput is one word per cycle.
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst        synchronous reset, active-high
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    flattened channel data; channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered output data
//   out_ch     index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
module mux_rr_nx1 #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int NI = int'(N);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Register is empty or being drained; reset suppresses any handshake.
  assign load = !rst && (!out_valid_q || out_ready);

  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    if (!mode) begin
      // sel >= N matches no channel, so it simply yields no grant.
      for (int i = 0; i < NI; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      // Scan from the farthest offset down so the nearest valid channel to rr_ptr wins.
      for (int k = NI - 1; k >= 0; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NI) j = j - NI;
        if (in_valid[j]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(j);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NI; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NI; i++) begin
      in_ready[i] = load && grant_valid && (grant_idx == SELW'(i));
    end
  end

  assign xfer = load && grant_valid;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = (grant_idx == SELW'(NI - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed bench for mux_rr_nx1. Uses a 4-channel instance for most scenarios and a 3-channel
// instance for reset-in-flight and out-of-range select.
module tb_mux_rr_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=4, WIDTH=8
  logic        rst, mode, out_ready, out_valid;
  logic [1:0]  sel, out_ch;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;

  // N=3, WIDTH=8
  logic        rst3, mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_ch3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;

  mux_rr_nx1 #(.N(4), .WIDTH(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_rr_nx1 #(.N(3), .WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst3),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ch4 [4];
    int exp_ch3 [5];
    exp_ch4 = '{3, 1, 3, 1};
    exp_ch3 = '{0, 1, 2, 0, 1};

    rst = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = 32'h13121110;
    rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
    in_valid3 = 3'b000; in_data3 = 24'h222120;

    // 1. Reset holds in_ready low and clears the output register.
    #1;
    check("rst_ready_0", 32'(in_ready), 32'h0);
    tick();
    check("rst_ready_1", 32'(in_ready), 32'h0);
    tick();
    check("rst_ready_2", 32'(in_ready), 32'h0);
    rst = 1'b0; in_valid = 4'b0000;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_ch", 32'(out_ch), 32'h0);

    // 2. Fixed mode.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000;
    #1;
    check("fix_ready", 32'(in_ready), 32'h4);
    tick();
    check("fix_valid", 32'(out_valid), 32'h1);
    check("fix_data", 32'(out_data), 32'hA5);
    check("fix_ch", 32'(out_ch), 32'h2);
    in_valid = 4'b1011;
    #1;
    check("fix_nogrant_ready", 32'(in_ready), 32'h0);
    tick();
    check("fix_drop_valid", 32'(out_valid), 32'h0);
    check("fix_hold_data", 32'(out_data), 32'hA5);

    // 3. Round-robin, all channels valid: 0,1,2,3,0,1 back-to-back.
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h13121110;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_all_valid", 32'(out_valid), 32'h1);
      check("rr_all_ch", 32'(out_ch), 32'(k % 4));
      check("rr_all_data", 32'(out_data), 32'(8'h10 + k % 4));
    end

    // 4. Sparse round-robin; rr_ptr is 2 here, so ch3 comes first.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_sparse_ch", 32'(out_ch), 32'(exp_ch4[k]));
      check("rr_sparse_data", 32'(out_data), 32'(8'h10 + exp_ch4[k]));
    end

    // 5. Backpressure on a word from ch2, then drain and reload on the same edge.
    in_valid = 4'b1111;
    tick();
    out_ready = 1'b0;
    #1;
    check("bp_ready_0", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_ready", 32'(in_ready), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_ch", 32'(out_ch), 32'h2);
      check("bp_data", 32'(out_data), 32'h12);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h8);
    tick();
    check("bp_reload_valid", 32'(out_valid), 32'h1);
    check("bp_reload_ch", 32'(out_ch), 32'h3);
    check("bp_reload_data", 32'(out_data), 32'h13);
    in_valid = 4'b0000;
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'h0);

    // 6. N=3: streaming, reset in flight, then out-of-range select.
    rst3 = 1'b0; mode3 = 1'b1; in_valid3 = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("n3_ch", 32'(out_ch3), 32'(exp_ch3[k]));
      check("n3_data", 32'(out_data3), 32'(8'h20 + exp_ch3[k]));
    end
    rst3 = 1'b1;
    #1;
    check("n3_rst_ready", 32'(in_ready3), 32'h0);
    tick();
    check("n3_rst_valid", 32'(out_valid3), 32'h0);
    check("n3_rst_ch", 32'(out_ch3), 32'h0);
    rst3 = 1'b0;
    #1;
    check("n3_post_rst_ready", 32'(in_ready3), 32'h1);
    tick();
    check("n3_post_rst_ch", 32'(out_ch3), 32'h0);
    check("n3_post_rst_data", 32'(out_data3), 32'h20);
    mode3 = 1'b0; sel3 = 2'd3;
    #1;
    check("n3_sel_oob_ready", 32'(in_ready3), 32'h0);
    tick();
    check("n3_sel_oob_valid", 32'(out_valid3), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
